// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 key schedule constants, state enum and word helpers
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int AES_RW = 4;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Word idx of a 128-bit block; w0 sits in the low 32 bits.
  function automatic logic [31:0] get_word(input logic [127:0] blk, input logic [1:0] idx);
    return blk[{idx, 5'b0} +: 32];
  endfunction

  // Byte 0 of a word is in [31:24], so {a,b,c,d} -> {b,c,d,a} is a left byte rotate.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box lookup
module aes_sbox (
  input  logic [7:0] value,
  output logic [7:0] subst
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign subst = SBOX[value];

endmodule

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - iterative AES-128 key schedule streaming round keys 0..NR
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int RW = AES_RW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [127:0]   key_in,
  input  logic           key_valid,
  output logic           key_ready,
  output logic [127:0]   rk_out,
  output logic [RW-1:0]  rk_round,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic           done
);

  state_t state, state_nxt;
  logic load, advance, finish;

  logic [31:0] w0, w1, w2, w3, rw, sw, t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = get_word(rk_out, 2'd0);
  assign w1 = get_word(rk_out, 2'd1);
  assign w2 = get_word(rk_out, 2'd2);
  assign w3 = get_word(rk_out, 2'd3);
  assign rw = rot_word(w3);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .value (rw[8*i +: 8]),
      .subst (sw[8*i +: 8])
    );
  end

  // Rcon index is that of the key being produced, one past the current round.
  assign t  = sw ^ {rcon(4'(rk_round + RW'(1))), 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (key_valid) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (rk_valid && rk_ready) begin
          if (rk_round == RW'(NR)) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rk_out   <= '0;
      rk_round <= '0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        rk_out   <= key_in;
        rk_round <= '0;
        rk_valid <= 1'b1;
      end else if (advance) begin
        rk_out   <= {n3, n2, n1, n0};
        rk_round <= rk_round + RW'(1);
      end else if (finish) begin
        rk_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - directed self-checking bench for aes_key_expand
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         done;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [127:0]              key;
    logic [10:0][127:0]        rk;
    logic [10:0]               known;
  } key_vec_t;

  key_vec_t vecs [2];

  aes_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk_out    (rk_out),
    .rk_round  (rk_round),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_key(input logic [127:0] k);
    int n = 0;
    while (!key_ready && n < 20) begin
      step();
      n++;
    end
    check("key_ready_wait", 128'(key_ready), 128'(1));
    key_in    = k;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  // Walks the stream from round 0; returns at the done cycle, or early at stop_round.
  task automatic stream(input int idx, input bit bp, input bit inject, input int stop_round);
    int r = 0;
    int cyc = 0;
    bit acc;
    while (r <= 10 && cyc < 300) begin
      rk_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      key_valid = inject && (r == 3);
      key_in    = ~vecs[idx].key;
      check("rk_valid", 128'(rk_valid), 128'(1));
      check("rk_round", 128'(rk_round), 128'(r));
      if (vecs[idx].known[r]) check($sformatf("rk_out_r%0d", r), rk_out, vecs[idx].rk[r]);
      if (r == stop_round) begin
        rk_ready  = 1'b1;
        key_valid = 1'b0;
        return;
      end
      acc = rk_ready;
      step();
      cyc++;
      if (acc) r++;
    end
    check("stream_timeout", 128'(r), 128'(11));
    rk_ready  = 1'b1;
    key_valid = 1'b0;
    check("done_pulse", 128'(done), 128'(1));
    check("rk_valid_end", 128'(rk_valid), 128'(0));
    check("key_ready_end", 128'(key_ready), 128'(1));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_key_ready"}, 128'(key_ready), 128'(1));
    check({tag, "_rk_valid"},  128'(rk_valid),  128'(0));
    check({tag, "_rk_out"},    rk_out,          128'(0));
    check({tag, "_rk_round"},  128'(rk_round),  128'(0));
    check({tag, "_done"},      128'(done),      128'(0));
  endtask

  initial begin
    vecs[0].key   = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
    vecs[0].known = 11'h7ff;
    vecs[0].rk[0]  = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
    vecs[0].rk[1]  = 128'h2a6c7605_23a33939_88542cb1_a0fafe17;
    vecs[0].rk[2]  = 128'h7359f67f_5935807a_7a96b943_f2c295f2;
    vecs[0].rk[3]  = 128'h6d7a883b_1e237e44_4716fe3e_3d80477d;
    vecs[0].rk[4]  = 128'hdb0bad00_b671253b_a8525b7f_ef44a541;
    vecs[0].rk[5]  = 128'h11f915bc_caf2b8bc_7c839d87_d4d1c6f8;
    vecs[0].rk[6]  = 128'hca0093fd_dbf98641_110b3efd_6d88a37a;
    vecs[0].rk[7]  = 128'h4ea6dc4f_84a64fb2_5f5fc9f3_4e54f70e;
    vecs[0].rk[8]  = 128'h7f8d292f_312bf560_b58dbad2_ead27321;
    vecs[0].rk[9]  = 128'h575c006e_28d12941_19fadc21_ac7766f3;
    vecs[0].rk[10] = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;

    vecs[1].key   = 128'h0c0d0e0f_08090a0b_04050607_00010203;
    vecs[1].known = 11'b100_0000_0011;
    for (int i = 0; i < 11; i++) vecs[1].rk[i] = '0;
    vecs[1].rk[0]  = 128'h0c0d0e0f_08090a0b_04050607_00010203;
    vecs[1].rk[1]  = 128'hd6ab76fe_daa678f1_d2af72fa_d6aa74fd;
    vecs[1].rk[10] = 128'h4d2b30c5_f307a78b_e3944a17_13111d7f;

    rst       = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    rk_ready  = 1'b1;
    step();
    step();
    check_reset_values("in_reset");
    rst = 1'b1;
    step();
    check_reset_values("after_reset");

    // Unstalled streams for both vectors.
    for (int v = 0; v < 2; v++) begin
      start_key(vecs[v].key);
      stream(v, 1'b0, 1'b0, -1);
      step();
      check("done_width", 128'(done), 128'(0));
    end

    // Random backpressure.
    for (int k = 0; k < 2; k++) begin
      start_key(vecs[0].key);
      stream(0, 1'b1, 1'b0, -1);
      step();
      check("done_width_bp", 128'(done), 128'(0));
    end

    // Stray key during RUN, then back-to-back key on the done cycle.
    start_key(vecs[0].key);
    stream(0, 1'b0, 1'b1, -1);
    key_in    = vecs[1].key;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    check("done_width_b2b", 128'(done), 128'(0));
    check("key_ready_b2b", 128'(key_ready), 128'(0));
    stream(1, 1'b0, 1'b0, -1);
    step();
    check("done_width_2", 128'(done), 128'(0));

    // Asynchronous reset at round 5.
    start_key(vecs[0].key);
    stream(0, 1'b0, 1'b0, 5);
    rst = 1'b0;
    #1;
    check_reset_values("mid_reset");
    step();
    check_reset_values("mid_reset_hold");
    rst = 1'b1;
    step();
    check_reset_values("post_release");
    start_key(vecs[1].key);
    stream(1, 1'b0, 1'b0, -1);
    step();
    check("done_width_3", 128'(done), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
